// File: rtl/deser_pattern_checker.sv
// Receive-side test-frame checker behind the SN65LV1224 deserializer.
// Aligns on the frame marker, checks every deterministic word, captures the
// per-frame random word and keeps error / frame / resync statistics.
module deser_pattern_checker #(
    parameter int unsigned FRAME_LENGTH_LOG2 = 5,
    parameter int unsigned COUNTER_WIDTH     = 32
) (
    input  logic                     clock,
    input  logic                     reset_active_low,
    input  logic                     lock_active_low,
    input  logic [9:0]               data_bus,
    input  logic                     clear_counters,
    output logic                     aligned,
    output logic                     frame_strobe,
    output logic                     word_error,
    output logic [9:0]               random_word,
    output logic                     random_valid,
    output logic [COUNTER_WIDTH-1:0] error_count,
    output logic [COUNTER_WIDTH-1:0] frame_count,
    output logic [COUNTER_WIDTH-1:0] resync_count
);

    localparam int unsigned WORD_W = 10;
    localparam int unsigned POS_W  = FRAME_LENGTH_LOG2;
    localparam int unsigned CNT_W  = COUNTER_WIDTH;

    localparam logic [WORD_W-1:0] WORD_ONES   = 10'b1111111111;
    localparam logic [WORD_W-1:0] WORD_ZERO   = 10'b0000000000;
    localparam logic [WORD_W-1:0] WORD_ALT    = 10'b0101010101;
    localparam logic [WORD_W-1:0] WORD_MARKER = 10'b0111111111;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_HUNT     = 2'd1,
        ST_CHECK    = 2'd2
    } state_e;

    state_e              state_q;
    logic                rst_sync_q;
    logic [POS_W-1:0]    pos_q;
    logic                aligned_q;
    logic                frame_strobe_q;
    logic                word_error_q;
    logic                random_valid_q;
    logic [WORD_W-1:0]   random_word_q;
    logic [CNT_W-1:0]    error_count_q;
    logic [CNT_W-1:0]    frame_count_q;
    logic [CNT_W-1:0]    resync_count_q;

    logic [31:0]         pos_wide_c;
    logic [WORD_W-1:0]   exp_word_c;
    logic                is_random_pos_c;
    logic                is_marker_pos_c;
    logic                frame_inc_c;
    logic                err_inc_c;
    logic                resync_inc_c;
    logic                capture_c;

    assign pos_wide_c      = 32'(pos_q);
    assign is_random_pos_c = (pos_wide_c == 32'd12);
    assign is_marker_pos_c = (pos_wide_c == 32'd1);

    // Expected word for the current frame position
    always_comb begin
        exp_word_c = WORD_ONES;
        if (pos_wide_c == 32'd0) begin
            exp_word_c = WORD_ONES;
        end else if (pos_wide_c < 32'd10) begin
            exp_word_c = WORD_ONES >> pos_wide_c[3:0];
        end else if (pos_wide_c == 32'd10) begin
            exp_word_c = WORD_ZERO;
        end else if (pos_wide_c == 32'd11) begin
            exp_word_c = WORD_ALT;
        end
    end

    // Decode the events caused by the word sampled on this edge
    always_comb begin
        frame_inc_c  = 1'b0;
        err_inc_c    = 1'b0;
        resync_inc_c = 1'b0;
        capture_c    = 1'b0;
        if (!lock_active_low) begin
            case (state_q)
                ST_HUNT: begin
                    frame_inc_c = (data_bus == WORD_MARKER);
                end
                ST_CHECK: begin
                    if (is_random_pos_c) begin
                        capture_c = 1'b1;
                    end else if (data_bus != exp_word_c) begin
                        err_inc_c    = 1'b1;
                        resync_inc_c = is_marker_pos_c;
                    end else if (is_marker_pos_c) begin
                        frame_inc_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Reset release synchroniser: logic becomes active on the second edge
    always_ff @(posedge clock or negedge reset_active_low) begin
        if (!reset_active_low) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
        end
    end

    // Alignment FSM, position tracking, pulses, capture and statistics
    always_ff @(posedge clock or negedge reset_active_low) begin
        if (!reset_active_low) begin
            state_q        <= ST_UNLOCKED;
            pos_q          <= '0;
            aligned_q      <= 1'b0;
            frame_strobe_q <= 1'b0;
            word_error_q   <= 1'b0;
            random_valid_q <= 1'b0;
            random_word_q  <= '0;
            error_count_q  <= '0;
            frame_count_q  <= '0;
            resync_count_q <= '0;
        end else if (rst_sync_q) begin
            frame_strobe_q <= frame_inc_c;
            word_error_q   <= err_inc_c;
            random_valid_q <= capture_c;
            if (capture_c) begin
                random_word_q <= data_bus;
            end

            if (lock_active_low) begin
                state_q   <= ST_UNLOCKED;
                aligned_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_UNLOCKED: begin
                        state_q <= ST_HUNT;
                    end
                    ST_HUNT: begin
                        if (frame_inc_c) begin
                            state_q   <= ST_CHECK;
                            aligned_q <= 1'b1;
                            pos_q     <= POS_W'(2);
                        end
                    end
                    ST_CHECK: begin
                        pos_q <= pos_q + POS_W'(1);
                        if (resync_inc_c) begin
                            state_q   <= ST_HUNT;
                            aligned_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q   <= ST_UNLOCKED;
                        aligned_q <= 1'b0;
                    end
                endcase

                // Clear wins over any coincident increment
                if (clear_counters) begin
                    error_count_q  <= '0;
                    frame_count_q  <= '0;
                    resync_count_q <= '0;
                end else begin
                    if (err_inc_c && !(&error_count_q)) begin
                        error_count_q <= error_count_q + CNT_W'(1);
                    end
                    if (resync_inc_c && !(&resync_count_q)) begin
                        resync_count_q <= resync_count_q + CNT_W'(1);
                    end
                    if (frame_inc_c) begin
                        frame_count_q <= frame_count_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign aligned      = aligned_q;
    assign frame_strobe = frame_strobe_q;
    assign word_error   = word_error_q;
    assign random_word  = random_word_q;
    assign random_valid = random_valid_q;
    assign error_count  = error_count_q;
    assign frame_count  = frame_count_q;
    assign resync_count = resync_count_q;

endmodule
